// File: rtl/float_div_pkg.sv
// Shared float format macros and the package for the iterative float divider.
// The macros are the single source of the exponent all-ones and NaN/overflow
// result patterns, shared by float_mult and float_div so that results chain.
// Package contents: derived widths, FSM state type, packed operand view and
// operand classification helpers.
`ifndef FLOAT_DEFINES_SV
`define FLOAT_DEFINES_SV
`ifndef E_bit
`define E_bit 8
`endif
`ifndef F_bit
`define F_bit 23
`endif
`define EXP_ONES {(`E_bit){1'b1}}
`define NAN_RES(s) {(s), `EXP_ONES, {(`F_bit-1){1'b0}}, 1'b1}
`endif

package float_div_pkg;

  localparam int EW = `E_bit;      // exponent field width
  localparam int FW = `F_bit;      // fraction field width
  localparam int W  = EW + FW + 1; // packed float width
  localparam int MW = FW + 1;      // mantissa width including hidden 1
  localparam int XW = EW + 2;      // signed working exponent width

  typedef enum logic [1:0] {IDLE, CALC, NORM, PACK} state_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [FW-1:0] frac;
  } fp_t;

  function automatic logic is_special(input logic [EW-1:0] e);
    return e == `EXP_ONES;
  endfunction

  function automatic logic is_zero(input logic [EW-1:0] e);
    return e == '0;
  endfunction

endpackage

// File: rtl/float_div_mant.sv
// Iterative restoring mantissa divider.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture ma (as initial remainder) and mb, clear q and counter
//   step       : produce one quotient bit
//   ma, mb     : mantissas with hidden 1
//   q          : quotient bits shifted in MSB-first
//   last       : the step taken this cycle is the final one
module float_div_mant
  import float_div_pkg::*;
#(
  parameter int ITER = FW + 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [MW-1:0]   ma,
  input  logic [MW-1:0]   mb,
  output logic [ITER-1:0] q,
  output logic            last
);

  localparam int CW = $clog2(ITER);
  // The remainder stays below 2*mb after each shift, so one extra bit suffices.
  localparam int RW = MW + 1;

  logic [RW-1:0] rem;
  logic [RW-1:0] rem_sub;
  logic [RW-1:0] mb_ext;
  logic [MW-1:0] mb_r;
  logic [CW-1:0] cnt;
  logic          ge;

  assign mb_ext  = {1'b0, mb_r};
  assign ge      = rem >= mb_ext;
  assign rem_sub = ge ? rem - mb_ext : rem;
  assign last    = cnt == CW'(ITER - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      mb_r <= '0;
      q    <= '0;
      cnt  <= '0;
    end else if (load) begin
      rem  <= {1'b0, ma};
      mb_r <= mb;
      q    <= '0;
      cnt  <= '0;
    end else if (step) begin
      q    <= {q[ITER-2:0], ge};
      rem  <= rem_sub << 1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/float_div.sv
// Iterative floating-point divider: out_q = div_a / div_b.
// Fixed latency of F_bit+5 cycles from the accepting edge for every input.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only while busy is low
//   div_a, div_b : dividend / divisor, captured on the accepting edge
//   busy         : operation in progress
//   done         : one-cycle pulse when out_q/div_zero are updated
//   out_q        : quotient, held until the next done
//   div_zero     : result came from a zero divisor
module float_div
  import float_div_pkg::*;
#(
  parameter logic [EW-1:0] E_ref = {(`E_bit-1){1'b1}},
  parameter int            ITER  = `F_bit + 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] div_a,
  input  logic [W-1:0] div_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out_q,
  output logic         div_zero
);

  localparam logic signed [XW-1:0] E_MAX = XW'((1 << EW) - 1);

  state_t state, state_nxt;
  fp_t    fa, fb;
  logic   load, step, last;
  logic [ITER-1:0] mant_q;

  logic                 sign_r, nan_r, zero_r, dz_r;
  logic signed [XW-1:0] exp_r;
  logic [FW-1:0]        frac_r;

  logic signed [XW-1:0] ea_s, eb_s, exp_calc, exp_t, exp_n;
  logic [FW-1:0]        frac_t, frac_n;
  logic [FW:0]          frac_rnd;
  logic                 rnd;

  function automatic logic [FW:0] round_half_up(input logic [FW-1:0] f, input logic r);
    return {1'b0, f} + {{FW{1'b0}}, r};
  endfunction

  function automatic logic [W-1:0] pack_result(input logic s, input logic nan,
                                               input logic zero,
                                               input logic signed [XW-1:0] e,
                                               input logic [FW-1:0] f);
    if (nan)               return `NAN_RES(s);
    if (zero || e <= 0)    return {s, {(W-1){1'b0}}};
    if (e >= E_MAX)        return `NAN_RES(s);
    return {s, e[EW-1:0], f};
  endfunction

  assign fa       = div_a;
  assign fb       = div_b;
  assign ea_s     = {2'b00, fa.exp};
  assign eb_s     = {2'b00, fb.exp};
  assign exp_calc = ea_s - eb_s + $signed({2'b00, E_ref});
  assign busy     = state != IDLE;

  float_div_mant #(.ITER(ITER)) u_mant (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .ma    ({1'b1, fa.frac}),
    .mb    ({1'b1, fb.frac}),
    .q     (mant_q),
    .last  (last)
  );

  // Normalisation: the leading 1 is in one of the top two quotient bits.
  always_comb begin
    if (mant_q[ITER-1]) begin
      frac_t = mant_q[ITER-2:2];
      rnd    = mant_q[1];
      exp_t  = exp_r;
    end else begin
      frac_t = mant_q[ITER-3:1];
      rnd    = mant_q[0];
      exp_t  = exp_r - XW'(1);
    end
    frac_rnd = round_half_up(frac_t, rnd);
    // On carry-out the low bits are already zero and the exponent absorbs it.
    frac_n   = frac_rnd[FW-1:0];
    exp_n    = frac_rnd[FW] ? exp_t + XW'(1) : exp_t;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = CALC;
        load      = 1'b1;
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = NORM;
      end
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      nan_r    <= 1'b0;
      zero_r   <= 1'b0;
      dz_r     <= 1'b0;
      exp_r    <= '0;
      frac_r   <= '0;
      out_q    <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Capture: sign, operand classes and biased exponent difference.
        IDLE: if (start) begin
          sign_r <= fa.sign ^ fb.sign;
          nan_r  <= is_special(fa.exp) | is_zero(fb.exp);
          zero_r <= is_zero(fa.exp) | is_special(fb.exp);
          dz_r   <= is_zero(fb.exp);
          exp_r  <= exp_calc;
        end
        // Normalise and round the finished quotient.
        NORM: begin
          exp_r  <= exp_n;
          frac_r <= frac_n;
        end
        // Pack, with specials taking priority over range checks.
        PACK: begin
          done     <= 1'b1;
          out_q    <= pack_result(sign_r, nan_r, zero_r, exp_r, frac_r);
          div_zero <= dz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
module tb_float_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] div_a, div_b;
  logic        busy, done, div_zero;
  logic [31:0] out_q;

  int checks   = 0;
  int failures = 0;

  float_div dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .div_a    (div_a),
    .div_b    (div_b),
    .busy     (busy),
    .done     (done),
    .out_q    (out_q),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: exact quotient rounded half-up to 24 significant bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic dz);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    dz = (eb == 0);
    if (ea == 255 || eb == 0) begin
      q = {s, 8'hFF, 23'h1};
      return;
    end
    if (ea == 0 || eb == 255) begin
      q = {s, 31'h0};
      return;
    end
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma >= mb) m = ((ma <<< 24) + mb) / (2 * mb);
    else begin
      m = ((ma <<< 25) + mb) / (2 * mb);
      e = e - 1;
    end
    if (m == (longint'(1) <<< 24)) begin
      m = longint'(1) <<< 23;
      e = e + 1;
    end
    if (e <= 0)        q = {s, 31'h0};
    else if (e >= 255) q = {s, 8'hFF, 23'h1};
    else               q = {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel == 2) e = 8'($urandom_range(1, 30));
    else if (sel == 3) e = 8'($urandom_range(225, 254));
    else               e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Start one divide, wait (bounded) for done; lat counts edges after accept.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output int lat);
    @(negedge clk);
    div_a = a;
    div_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    r = out_q;
    z = div_zero;
  endtask

  initial begin
    logic [31:0] r, eq;
    logic        z, ez;
    int          lat, n, seen;
    bit          got;

    vecs[0] = '{"6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1] = '{"1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
    vecs[2] = '{"-1/0.5",     32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0};
    vecs[3] = '{"1/0",        32'h3F800000, 32'h00000000, 32'h7F800001, 1'b1};
    vecs[4] = '{"0/2",        32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[5] = '{"overflow",   32'h7F000000, 32'h00800000, 32'h7F800001, 1'b0};
    vecs[6] = '{"underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    div_a = '0;
    div_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset out_q", out_q, 32'h0);
    check("reset div_zero", 32'(div_zero), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].a, vecs[i].b, r, z, lat);
      check({vecs[i].name, " q"}, r, vecs[i].q);
      check({vecs[i].name, " div_zero"}, 32'(z), 32'(vecs[i].dz));
      check({vecs[i].name, " latency"}, 32'(lat), 32'd28);
    end

    // Starts while busy are ignored; a start in the done cycle is accepted.
    @(negedge clk);
    div_a = 32'h40C00000;
    div_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1'b1;
      else if (n == 5 || n == 20) begin
        check($sformatf("busy at cycle %0d", n), 32'(busy), 32'h1);
        start = 1'b1;
        div_a = 32'h3F800000;
        div_b = 32'h00000000;
      end else start = 1'b0;
    end
    check("busy-start latency", 32'(n), 32'd28);
    check("busy-start q", out_q, 32'h40400000);
    check("busy-start div_zero", 32'(div_zero), 32'h0);
    check("busy low with done", 32'(busy), 32'h0);
    div_a = 32'h3F800000;
    div_b = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    check("back-to-back latency", 32'(n), 32'd28);
    check("back-to-back q", out_q, 32'h3EAAAAAB);

    // Reset in the middle of an operation.
    run_div(32'h3F800000, 32'h00000000, r, z, lat);
    check("pre-reset div_zero", 32'(z), 32'h1);
    @(negedge clk);
    div_a = 32'h40C00000;
    div_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid-reset out_q", out_q, 32'h0);
    check("mid-reset div_zero", 32'(div_zero), 32'h0);
    check("mid-reset busy", 32'(busy), 32'h0);
    check("mid-reset done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no done after reset", 32'(seen), 32'h0);
    run_div(32'h40C00000, 32'h40000000, r, z, lat);
    check("post-reset q", r, 32'h40400000);
    check("post-reset latency", 32'(lat), 32'd28);

    // Randomised operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      model(a, b, eq, ez);
      run_div(a, b, r, z, lat);
      check($sformatf("rand%0d q (a=%08h b=%08h)", i, a, b), r, eq);
      check($sformatf("rand%0d div_zero", i), 32'(z), 32'(ez));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
